// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for a whole CYC
// and an ack watchdog that force-terminates stalled cycles and records a sticky bus error.
module wb_bus_arbiter #(
   parameter int unsigned  ADDRESS_WIDTH = 24,
   parameter logic [15:0]  ACK_TIMEOUT   = 16'd64,
   parameter logic [15:0]  ERR_DATA      = 16'hDEAD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] m0AdrI,
   input  logic [15:0]              m0DatI,
   output logic [15:0]              m0DatO,
   input  logic                     m0CycI,
   input  logic                     m0StbI,
   input  logic                     m0WeI,
   output logic                     m0AckO,
   input  logic [ADDRESS_WIDTH-1:0] m1AdrI,
   input  logic [15:0]              m1DatI,
   output logic [15:0]              m1DatO,
   input  logic                     m1CycI,
   input  logic                     m1StbI,
   input  logic                     m1WeI,
   output logic                     m1AckO,
   output logic [ADDRESS_WIDTH-1:0] sAdrO,
   output logic [15:0]              sDatO,
   input  logic [15:0]              sDatI,
   output logic                     sCycO,
   output logic                     sStbO,
   output logic                     sWeO,
   input  logic                     sAckI,
   output logic [1:0]               grant,
   output logic                     busError,
   output logic [7:0]               errorCount,
   input  logic                     errorClear
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, FORCE_ACK} state_t;

   state_t      state, state_next;
   logic [1:0]  grant_next;
   logic        last_grant, last_grant_next;   // 0 = m0 granted last, 1 = m1
   logic [15:0] wd_count, wd_count_next;
   logic        owner1, owner_cyc, owner_stb, stalled;

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      last_grant_next = last_grant;
      wd_count_next   = '0;
      sAdrO  = '0;
      sDatO  = '0;
      sCycO  = 1'b0;
      sStbO  = 1'b0;
      sWeO   = 1'b0;
      m0AckO = 1'b0;
      m1AckO = 1'b0;
      m0DatO = '0;
      m1DatO = '0;
      owner1    = grant[1];
      owner_cyc = owner1 ? m1CycI : m0CycI;
      owner_stb = owner1 ? m1StbI : m0StbI;
      stalled   = (ACK_TIMEOUT != 16'd0) && owner_stb && !sAckI;

      case (state)
         IDLE: begin
            grant_next = '0;
            // On a tie the master that did not win last time is served
            if (m0CycI && (!m1CycI || last_grant)) begin
               state_next      = OWN0;
               grant_next      = 2'b01;
               last_grant_next = 1'b0;
            end else if (m1CycI) begin
               state_next      = OWN1;
               grant_next      = 2'b10;
               last_grant_next = 1'b1;
            end
         end
         OWN0, OWN1: begin
            sAdrO = owner1 ? m1AdrI : m0AdrI;
            sDatO = owner1 ? m1DatI : m0DatI;
            sWeO  = owner1 ? m1WeI  : m0WeI;
            sCycO = owner_cyc;
            sStbO = owner_stb;
            if (owner1) begin
               m1AckO = sAckI;
               m1DatO = sDatI;
            end else begin
               m0AckO = sAckI;
               m0DatO = sDatI;
            end
            if (stalled)
               wd_count_next = wd_count + 16'd1;
            if (!owner_cyc) begin
               state_next    = IDLE;
               grant_next    = '0;
               wd_count_next = '0;
            end else if (stalled && (wd_count == ACK_TIMEOUT - 16'd1)) begin
               state_next    = FORCE_ACK;
               wd_count_next = '0;
            end
         end
         FORCE_ACK: begin
            if (owner1) begin
               m1AckO = 1'b1;
               m1DatO = ERR_DATA;
            end else begin
               m0AckO = 1'b1;
               m0DatO = ERR_DATA;
            end
            if (owner_cyc) begin
               state_next = owner1 ? OWN1 : OWN0;
            end else begin
               state_next = IDLE;
               grant_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= 1'b1;
         wd_count   <= '0;
         busError   <= 1'b0;
         errorCount <= '0;
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         last_grant <= last_grant_next;
         wd_count   <= wd_count_next;
         // A forced termination outranks a simultaneous clear
         if (state == FORCE_ACK) begin
            busError <= 1'b1;
            if (errorClear)
               errorCount <= 8'd1;
            else if (errorCount != 8'hFF)
               errorCount <= errorCount + 8'd1;
         end else if (errorClear) begin
            busError   <= 1'b0;
            errorCount <= '0;
         end
      end
   end

endmodule
